// File: rtl/window_stream_unit.sv
// Streaming WINxWIN window generator: WIN-1 inferred line buffers feed a shift-register window.
// Optional zero-padding of border taps is enabled with the WINDOW_BORDER_MASK_EN macro.
module window_stream_unit #(
    parameter int unsigned DATA_W    = 9,
    parameter int unsigned WIN       = 3,
    parameter int unsigned MAX_WIDTH = 1024,
    parameter int unsigned ADDR_W    = 10
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       reflesh,
    input  logic [31:0]                image_width,
    input  logic                       in_valid,
    input  logic [DATA_W-1:0]          data_in,
    output logic [DATA_W*WIN*WIN-1:0]  win_bus,
    output logic                       win_valid,
    output logic                       eol,
    output logic                       width_err
);

    localparam int unsigned BUS_W = DATA_W * WIN * WIN;
    localparam int unsigned RF_W  = $clog2(WIN);

    logic [ADDR_W-1:0]            col;
    logic [ADDR_W-1:0]            wlat_m1;
    logic [RF_W-1:0]              row_fill;
    logic [BUS_W-1:0]             taps;
    logic [BUS_W-1:0]             taps_nxt;
    logic [WIN-1:0][DATA_W-1:0]   src;
    logic [DATA_W-1:0]            mem [WIN-1][MAX_WIDTH];
    logic                         accept;
    logic                         last_col;
    logic                         width_bad;
    logic                         valid_nxt;

    assign accept    = in_valid & ~reflesh;
    assign last_col  = (col == wlat_m1);
    assign width_bad = (image_width == 32'd0) || (image_width > 32'(MAX_WIDTH));

    // Row sources: newest row is the input pixel, older rows come from the buffer chain
    always_comb begin
        src    = '0;
        src[0] = data_in;
        for (int k = 1; k < WIN; k++) begin
            src[k] = mem[k-1][col];
        end
    end

    // Window shift: column 0 loads the row source, other columns shift right
    always_comb begin
        taps_nxt = taps;
        for (int r = 0; r < WIN; r++) begin
            for (int c = 0; c < WIN; c++) begin
                if (c == 0) begin
                    taps_nxt[(r*WIN)*DATA_W +: DATA_W] = src[r];
                end else begin
                    taps_nxt[((r*WIN)+c)*DATA_W +: DATA_W] = taps[((r*WIN)+c-1)*DATA_W +: DATA_W];
                end
            end
        end
    end

`ifdef WINDOW_BORDER_MASK_EN
    assign valid_nxt = 1'b1;
`else
    assign valid_nxt = (row_fill == RF_W'(WIN-1)) && (col >= ADDR_W'(WIN-1));
`endif

    // Line buffers: asynchronous read of the old word, write on accept
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int k = 0; k < WIN-1; k++) begin
                mem[k][col] <= src[k];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            taps      <= '0;
            col       <= '0;
            row_fill  <= '0;
            win_valid <= 1'b0;
            eol       <= 1'b0;
            wlat_m1   <= ADDR_W'(MAX_WIDTH-1);
            width_err <= 1'b0;
        end else if (reflesh) begin
            taps      <= '0;
            col       <= '0;
            row_fill  <= '0;
            win_valid <= 1'b0;
            eol       <= 1'b0;
            if (width_bad) begin
                wlat_m1   <= ADDR_W'(MAX_WIDTH-1);
                width_err <= 1'b1;
            end else begin
                wlat_m1   <= ADDR_W'(image_width - 32'd1);
            end
        end else if (in_valid) begin
            taps      <= taps_nxt;
            win_valid <= valid_nxt;
            eol       <= last_col;
            if (last_col) begin
                col <= '0;
                if (row_fill != RF_W'(WIN-1)) begin
                    row_fill <= row_fill + RF_W'(1);
                end
            end else begin
                col <= col + ADDR_W'(1);
            end
        end else begin
            win_valid <= 1'b0;
            eol       <= 1'b0;
        end
    end

`ifdef WINDOW_BORDER_MASK_EN
    logic [BUS_W-1:0] masked;

    // Zero taps left of column 0 or above image row 0; shift contents stay raw
    always_comb begin
        masked = taps_nxt;
        for (int r = 0; r < WIN; r++) begin
            for (int c = 0; c < WIN; c++) begin
                if ((ADDR_W'(c) > col) || (RF_W'(r) > row_fill)) begin
                    masked[((r*WIN)+c)*DATA_W +: DATA_W] = '0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            win_bus <= '0;
        end else if (reflesh) begin
            win_bus <= '0;
        end else if (in_valid) begin
            win_bus <= masked;
        end
    end
`else
    assign win_bus = taps;
`endif

endmodule

// File: tb/tb_window_stream_unit.sv
// Randomised bench for window_stream_unit against a linear-pixel-index frame model.
module tb_window_stream_unit;

    localparam int unsigned DATA_W    = 9;
    localparam int unsigned WIN       = 3;
    localparam int unsigned MAX_WIDTH = 1024;
    localparam int unsigned ADDR_W    = 10;
    localparam int unsigned BUS_W     = DATA_W * WIN * WIN;

    logic               clk;
    logic               rst;
    logic               reflesh;
    logic [31:0]        image_width;
    logic               in_valid;
    logic [DATA_W-1:0]  data_in;
    logic [BUS_W-1:0]   win_bus;
    logic               win_valid;
    logic               eol;
    logic               width_err;

    window_stream_unit #(
        .DATA_W(DATA_W), .WIN(WIN), .MAX_WIDTH(MAX_WIDTH), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .rst(rst), .reflesh(reflesh), .image_width(image_width),
        .in_valid(in_valid), .data_in(data_in), .win_bus(win_bus),
        .win_valid(win_valid), .eol(eol), .width_err(width_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Frame model: every accepted pixel of the current frame, in raster order
    int             pix[$];
    int             w_m;
    bit             err_m;
    logic [BUS_W-1:0] exp_bus;
    logic [BUS_W-1:0] exp_known;
    bit             exp_v;
    bit             exp_e;

    task automatic check(input string tag, input logic [BUS_W-1:0] got, input logic [BUS_W-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_clear();
        pix.delete();
        exp_bus   = '0;
        exp_known = '1;
        exp_v     = 1'b0;
        exp_e     = 1'b0;
    endfunction

    // Tap (r,c) after pixel n is pixel n - c - r*width of the frame
    function automatic void model_accept(input int d);
        int n, row, colm, idx, tap;
        bit known;
        pix.push_back(d);
        n    = pix.size() - 1;
        row  = n / w_m;
        colm = n % w_m;
        exp_e = (colm == w_m - 1);
`ifdef WINDOW_BORDER_MASK_EN
        exp_v = 1'b1;
`else
        exp_v = (row >= WIN - 1) && (colm >= WIN - 1);
`endif
        for (int r = 0; r < WIN; r++) begin
            for (int c = 0; c < WIN; c++) begin
                idx   = n - c - r * w_m;
                tap   = 0;
                known = 1'b1;
`ifdef WINDOW_BORDER_MASK_EN
                if (c <= colm && r <= row) tap = pix[idx];
`else
                if (idx >= 0) tap = pix[idx];
                else if (n - c >= 0) known = 1'b0;
`endif
                exp_bus[((r*WIN)+c)*DATA_W +: DATA_W]   = DATA_W'(tap);
                exp_known[((r*WIN)+c)*DATA_W +: DATA_W] = known ? '1 : '0;
            end
        end
    endfunction

    task automatic step(input bit v, input bit rf, input int d);
        in_valid = v;
        reflesh  = rf;
        data_in  = DATA_W'(d);
        @(posedge clk);
        #1;
        if (rf) begin
            if (image_width == 0 || image_width > MAX_WIDTH) begin
                w_m   = MAX_WIDTH;
                err_m = 1'b1;
            end else begin
                w_m = int'(image_width);
            end
            model_clear();
        end else if (v) begin
            model_accept(d % (1 << DATA_W));
        end else begin
            exp_v = 1'b0;
            exp_e = 1'b0;
        end
        check("win_valid", BUS_W'(win_valid), BUS_W'(exp_v));
        check("eol", BUS_W'(eol), BUS_W'(exp_e));
        check("width_err", BUS_W'(width_err), BUS_W'(err_m));
        if (exp_known != '0) check("win_bus", win_bus & exp_known, exp_bus & exp_known);
    endtask

    task automatic refl(input int unsigned iw);
        image_width = iw;
        step(1'b1, 1'b1, 0);
    endtask

    // Asynchronous reset placed between clock edges
    task automatic async_reset();
        #2;
        rst = 1'b0;
        #1;
        check("rst_win_valid", BUS_W'(win_valid), '0);
        check("rst_eol", BUS_W'(eol), '0);
        check("rst_win_bus", win_bus, '0);
        check("rst_width_err", BUS_W'(width_err), '0);
        err_m = 1'b0;
        w_m   = MAX_WIDTH;
        model_clear();
        @(negedge clk);
        #3;
        rst = 1'b1;
    endtask

    logic [BUS_W-1:0] lit;
    int vals[9] = '{19, 18, 17, 11, 10, 9, 3, 2, 1};
    int eol_seen;

    initial begin
        rst = 1'b0; reflesh = 1'b0; in_valid = 1'b0; data_in = '0; image_width = 32'd8;
        err_m = 1'b0; w_m = MAX_WIDTH;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        check("reset_win_valid", BUS_W'(win_valid), '0);
        check("reset_eol", BUS_W'(eol), '0);
        check("reset_win_bus", win_bus, '0);
        check("reset_width_err", BUS_W'(width_err), '0);
        @(negedge clk);
        rst = 1'b1;

        // Continuous stream, width 8
        refl(8);
        for (int i = 1; i <= 24; i++) begin
            step(1'b1, 1'b0, i);
            if (i == 19) begin
                for (int t = 0; t < 9; t++) lit[t*DATA_W +: DATA_W] = DATA_W'(vals[t]);
                check("win_at_19", win_bus, lit);
            end
        end

        // Same stream, valid toggling
        refl(8);
        for (int i = 1; i <= 24; i++) begin
            step(1'b1, 1'b0, i);
            step(1'b0, 1'b0, 0);
        end

        // Reflesh coincident with a valid pixel drops it
        refl(8);
        for (int i = 1; i <= 12; i++) step(1'b1, 1'b0, i);
        image_width = 32'd8;
        step(1'b1, 1'b1, 13);
        check("refl_drop_bus", win_bus, '0);
        for (int i = 1; i <= 24; i++) step(1'b1, 1'b0, i);

        // Zero width falls back to the full line length and sets the sticky error
        refl(0);
        eol_seen = 0;
        for (int i = 1; i <= 1030; i++) begin
            step(1'b1, 1'b0, int'($urandom_range(0, 511)));
            if (eol && eol_seen == 0) eol_seen = i;
        end
        check("eol_at_1024", BUS_W'(eol_seen), BUS_W'(1024));
        refl(8);
        for (int i = 1; i <= 5; i++) step(1'b1, 1'b0, i);
        check("err_sticky", BUS_W'(width_err), BUS_W'(1));
        async_reset();

        refl(5000);
        for (int i = 1; i <= 4; i++) step(1'b1, 1'b0, i);
        async_reset();

        // Randomised frames with small widths, random gaps and occasional reflesh
        refl(8);
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 59) == 0) begin
                case ($urandom_range(0, 6))
                    0: refl(1);
                    1: refl(2);
                    2: refl(3);
                    3: refl(4);
                    4: refl(5);
                    5: refl(13);
                    default: refl(8);
                endcase
            end else begin
                step($urandom_range(0, 9) < 7, 1'b0, int'($urandom_range(0, 511)));
            end
            if (i == 400) async_reset();
            if (i == 400) refl(6);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
